udp_tx_arbiter: RTL and testbench

Shares one UDP TX FIFO pair (8-bit data FIFO plus 96-bit status FIFO) of the 1 Gb Ethernet wrapper between NUM_REQ packet sources, such as the command-ack generator and the acquisition streamer.
- Round-robin arbitration at packet granularity.
- Forwards payload bytes, counts them, then writes one status word per packet with the length field filled in by the arbiter.
- Sits in the rx_xcvr_clk (125 MHz) domain, between the port decoders and eth_1gb_wrapper.

---
 rtl/udp_tx_pkg.sv | 15 +
 rtl/udp_tx_arbiter_rr_pick.sv | 26 ++
 rtl/udp_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP TX arbiter: status word layout and FSM encoding.
package udp_tx_pkg;

    localparam int LEN_LSB  = 0;
    localparam int LEN_MSB  = 15;
    localparam int STATUS_W = 96;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STATUS = 2'd2,
        DRAIN  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, one-hot.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UDP TX data/status FIFO pair.
// Optional idle watchdog inside a packet: define TX_ARB_WATCHDOG_EN.
module udp_tx_arbiter
    import udp_tx_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_LEN     = 1472,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][STATUS_W-1:0] req_status,
    input  logic [NUM_REQ-1:0][7:0]          src_data,
    input  logic [NUM_REQ-1:0]               src_valid,
    input  logic [NUM_REQ-1:0]               src_last,
    output logic [NUM_REQ-1:0]               src_ready,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               done,
    output logic [NUM_REQ-1:0]               err_len,
    output logic [7:0]                       tx_fifo_data,
    output logic                             tx_fifo_data_write,
    input  logic                             tx_fifo_data_full,
    output logic [STATUS_W-1:0]              tx_fifo_status,
    output logic                             tx_fifo_status_write,
    input  logic                             tx_fifo_status_full
);

    localparam int PW = $clog2(NUM_REQ);

    tx_state_e                  state, state_nx;
    logic [PW-1:0]              ptr, ptr_nx, owner, pick_idx;
    logic [NUM_REQ-1:0]         pick_oh;
    logic                       pick_vld;
    logic [STATUS_W-1:LEN_MSB+1] hdr;
    logic [15:0]                cnt;
    logic                       trunc;
    logic                       accept;
    logic                       wd_fire;

    // The length field of each source's status word is overwritten by the byte count.
    logic unused_len_in;
    assign unused_len_in = ^req_status;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_oh),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_oh[i]) pick_idx = PW'(i);
    end

    assign ptr_nx = (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES);
    logic [WD_W-1:0] wd;

    assign wd_fire = (state == DATA) && !src_valid[owner] && (wd == WD_W'(WDOG_CYCLES-1));

    always_ff @(posedge clk) begin
        if (reset || state != DATA || src_valid[owner]) wd <= '0;
        else                                            wd <= wd + 1'b1;
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wd_fire     = 1'b0;
`endif

    always_comb begin
        state_nx             = state;
        src_ready            = '0;
        done                 = '0;
        err_len              = '0;
        accept               = 1'b0;
        tx_fifo_data         = src_data[owner];
        tx_fifo_data_write   = 1'b0;
        tx_fifo_status       = '0;
        tx_fifo_status_write = 1'b0;
        case (state)
            IDLE: if (pick_vld) state_nx = DATA;
            DATA: begin
                src_ready[owner]   = ~tx_fifo_data_full;
                accept             = src_valid[owner] & ~tx_fifo_data_full;
                tx_fifo_data_write = accept;
                if (accept && (src_last[owner] || cnt == 16'(MAX_LEN-1))) begin
                    state_nx = STATUS;
                    if (!src_last[owner]) err_len[owner] = 1'b1;
                end
                // Watchdog: a started packet is closed as truncated, an empty one is dropped.
                if (wd_fire) begin
                    if (cnt != '0) begin
                        err_len[owner] = 1'b1;
                        state_nx       = STATUS;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            STATUS: begin
                tx_fifo_status[STATUS_W-1:LEN_MSB+1] = hdr;
                tx_fifo_status[LEN_MSB:LEN_LSB]      = cnt;
                tx_fifo_status_write                 = ~tx_fifo_status_full;
                if (!tx_fifo_status_full) begin
                    done[owner] = 1'b1;
                    state_nx    = trunc ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                src_ready[owner] = 1'b1;
                if (src_valid[owner] && src_last[owner]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            hdr   <= '0;
            trunc <= 1'b0;
            grant <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_vld) begin
                grant <= pick_oh;
                owner <= pick_idx;
                hdr   <= req_status[pick_idx][STATUS_W-1:LEN_MSB+1];
                cnt   <= '0;
                trunc <= 1'b0;
            end
            if (accept)   cnt   <= cnt + 16'd1;
            if (|err_len) trunc <= 1'b1;
            if (state != IDLE && state_nx == IDLE) grant <= '0;
            if (tx_fifo_status_write || (state == DATA && state_nx == IDLE)) ptr <= ptr_nx;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: expected bytes/status words queued at drive time, checked at FIFO writes.
module tb_udp_tx_arbiter;

    localparam int NR  = 2;
    localparam int ML  = 1472;
    localparam int WD  = 16;
    localparam int LIM = 4000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req;
    logic [NR-1:0][95:0]  req_status;
    logic [NR-1:0][7:0]   src_data;
    logic [NR-1:0]        src_valid, src_last, src_ready, grant, done, err_len;
    logic [7:0]           tx_fifo_data;
    logic                 tx_fifo_data_write, tx_fifo_data_full;
    logic [95:0]          tx_fifo_status;
    logic                 tx_fifo_status_write, tx_fifo_status_full;

    logic [7:0]  exp_data[$];
    logic [95:0] exp_st[$];
    int          exp_src[$];
    int          n_chk = 0, n_fail = 0, exp_err = 0, err_seen = 0;

    localparam logic [95:0] ST0 = 96'h0011_2233_4455_6677_8899_BEEF;
    localparam logic [95:0] ST1 = 96'hA0A1_A2A3_A4A5_A6A7_A8A9_1234;

    udp_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .WDOG_CYCLES(WD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req                  (req),
        .req_status           (req_status),
        .src_data             (src_data),
        .src_valid            (src_valid),
        .src_last             (src_last),
        .src_ready            (src_ready),
        .grant                (grant),
        .done                 (done),
        .err_len              (err_len),
        .tx_fifo_data         (tx_fifo_data),
        .tx_fifo_data_write   (tx_fifo_data_write),
        .tx_fifo_data_full    (tx_fifo_data_full),
        .tx_fifo_status       (tx_fifo_status),
        .tx_fifo_status_write (tx_fifo_status_write),
        .tx_fifo_status_full  (tx_fifo_status_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_fifo_data_write || exp_data.size() == 0) begin
                if (tx_fifo_data_write) chk("data_wr_expected", tx_fifo_data_write, exp_data.size() != 0);
                if (tx_fifo_data_write && exp_data.size() != 0) chk("data_byte", tx_fifo_data, exp_data.pop_front());
            end
            if (tx_fifo_status_write) begin
                chk("st_wr_expected", tx_fifo_status_write, exp_st.size() != 0);
                if (exp_st.size() != 0) begin
                    chk("st_word", tx_fifo_status, exp_st.pop_front());
                    chk("done_src", done, NR'(1) << exp_src.pop_front());
                end
            end else if (done != '0) begin
                chk("done_no_wr", done, '0);
            end
            if (tx_fifo_data_full) chk("full_block", {tx_fifo_data_write, src_ready}, '0);
            if (|err_len) err_seen++;
        end
    end

    task automatic run_src(input int s, input int n, input logic [7:0] base, input logic [95:0] st,
                           input bit keep, input bit last);
        int cyc;
        bit got_done;
        got_done      = 1'b0;
        req_status[s] = st;
        req[s]        = 1'b1;
        cyc = 0;
        while (!grant[s] && cyc < LIM) begin @(posedge clk); #1; cyc++; end
        chk("grant_wait", cyc < LIM, 1'b1);
        for (int b = 0; b < n; b++) begin
            src_data[s]  = base + 8'(b);
            src_valid[s] = 1'b1;
            src_last[s]  = last && (b == n-1);
            if (b < ML) exp_data.push_back(base + 8'(b));
            if (b == ML-1 && !src_last[s]) begin
                exp_st.push_back({st[95:16], 16'(ML)}); exp_src.push_back(s); exp_err++;
            end else if (src_last[s] && b < ML) begin
                exp_st.push_back({st[95:16], 16'(n)}); exp_src.push_back(s);
            end
            cyc = 0;
            do begin
                @(negedge clk); cyc++;
                if (done[s]) begin got_done = 1'b1; if (!keep) req[s] = 1'b0; end
            end while (!src_ready[s] && cyc < LIM);
            if (cyc >= LIM) chk("ready_wait", src_ready[s], 1'b1);
            @(posedge clk); #1;
        end
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
        cyc = 0;
        while (!got_done && cyc < LIM) begin
            @(negedge clk); cyc++;
            if (done[s]) begin got_done = 1'b1; if (!keep) req[s] = 1'b0; end
        end
        chk("done_wait", got_done, 1'b1);
    endtask

    task automatic wait_release(input int s, input int lim);
        int cyc = 0;
        while (grant[s] && cyc < lim) begin @(negedge clk); cyc++; end
        chk("release", grant[s], 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int cyc;
        req = '0; req_status = '0; src_data = '0; src_valid = '0; src_last = '0;
        tx_fifo_data_full = 1'b0; tx_fifo_status_full = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {grant, src_ready, done, err_len, tx_fifo_data_write, tx_fifo_status_write}, '0);
        chk("rst_status", tx_fifo_status, '0);
        @(posedge clk); #1 reset = 1'b0;

        // Round robin from pointer 0, then wrap back to source 0
        req_status[0] = ST0; req_status[1] = ST1; req = 2'b11;
        @(posedge clk); #1;
        chk("rr_first", grant, 2'b01);
        fork
            run_src(0, 3, 8'h10, ST0, 1'b1, 1'b1);
            run_src(1, 3, 8'h20, ST1, 1'b1, 1'b1);
        join
        cyc = 0;
        while (!grant[0] && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("rr_wrap", grant, 2'b01);
        req[1] = 1'b0;
        run_src(0, 2, 8'h30, ST0, 1'b0, 1'b1);
        wait_release(0, 20);

        // Single source, 4 bytes
        run_src(0, 4, 8'hA1, ST1, 1'b0, 1'b1);
        wait_release(0, 20);

        // Data FIFO full for 5 cycles mid-packet
        fork
            run_src(1, 8, 8'h50, ST0, 1'b0, 1'b1);
            begin
                cyc = 0;
                while (!grant[1] && cyc < LIM) begin @(posedge clk); #1; cyc++; end
                repeat (2) begin @(posedge clk); #1; end
                tx_fifo_data_full = 1'b1;
                repeat (5) begin @(posedge clk); #1; end
                tx_fifo_data_full = 1'b0;
            end
        join
        wait_release(1, 20);

        // Status FIFO full for the first 3 STATUS cycles
        tx_fifo_status_full = 1'b1;
        fork
            run_src(0, 2, 8'h60, ST1, 1'b0, 1'b1);
            begin
                cyc = 0;
                do begin @(negedge clk); cyc++; end
                while (!(tx_fifo_data_write && src_last[0]) && cyc < LIM);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("sfull_hold", {tx_fifo_status_write, done}, '0);
                end
                @(posedge clk); #1 tx_fifo_status_full = 1'b0;
                @(negedge clk);
                chk("sfull_write", {tx_fifo_status_write, done}, {1'b1, 2'b01});
            end
        join
        wait_release(0, 20);

        // Oversized packet: truncate at MAX_LEN, drain the rest
        run_src(1, 1500, 8'h00, ST0, 1'b0, 1'b1);
        wait_release(1, 20);
        chk("trunc_err", err_seen, exp_err);

`ifdef TX_ARB_WATCHDOG_EN
        // Watchdog with 3 bytes sent: truncated status, then drain to last
        exp_st.push_back({ST1[95:16], 16'd3}); exp_src.push_back(0); exp_err++;
        run_src(0, 3, 8'h70, ST1, 1'b0, 1'b0);
        src_valid[0] = 1'b1; src_last[0] = 1'b1;
        @(posedge clk); #1;
        src_valid[0] = 1'b0; src_last[0] = 1'b0;
        wait_release(0, 20);
        // Watchdog with no bytes: grant released, no status
        req[0] = 1'b1;
        cyc = 0;
        while (!grant[0] && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("wd0_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_release(0, WD + 8);
        chk("wd_err", err_seen, exp_err);
`endif

        repeat (5) @(posedge clk);
        chk("data_q_left", exp_data.size(), 0);
        chk("st_q_left", exp_st.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
